ej32_fetch: RTL
===============

# ej32_fetch

Byte-serial instruction fetch and sequencing unit for the eJ32 Java Forth machine. It reads one opcode byte and its operand bytes over a req/ack memory port. For every byte it presents `code`, `phase` and `data` to the execution units (ALU, branching, load/store), together with the current instruction pointer. It is the consumer of the branching unit's redirect outputs: it samples the jump target and select on each step and restarts fetch there.

## Interface
Parameters:
- `DSZ`, 32, data width (passed through to the shared package; not used for datapath here)
- `ASZ`, 17, instruction address width (128K space)

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, **asynchronous, active-high**.
- `en` in 1: fetch enable; 0 stops new memory requests.
- `mem_req` out 1: memory read request.
- `mem_addr` out ASZ: byte address for the request.
- `mem_ack` in 1: the read has completed and `mem_data` is valid.
- `mem_data` in 8: returned byte.
- `br_psel` in 1: redirect request from the branching unit.
- `br_p_o` in ASZ: redirect target address.
- `code` out 8 (`opcode_t`): current opcode.
- `phase` out 3: operand index of the current step.
- `data` out 8: byte of the current step.
- `p` out ASZ: address of the byte on `data`.
- `step` out 1: single-cycle strobe; execution units act only while it is 1.

## Operation
- FSM states:
  - S_OP: `mem_req`=1, `mem_addr`=`pc`. On ack:
    - `code`←`mem_data`, `data`←`mem_data`, `p`←`pc`, `phase`←0.
    - `op_len(code)`=0 → S_STEP; otherwise `pc`←`pc`+1 → S_ARG.
  - S_ARG: `mem_req`=1, `mem_addr`=`pc`. On ack: `data`←`mem_data`, `p`←`pc` → S_STEP.
  - S_STEP: `step`=1 for exactly one cycle. Next state is chosen by the first matching rule:
    - `br_psel`=1 → `pc`←`br_p_o`, `phase`←0, go to S_OP. Any remaining operand bytes are discarded.
    - `phase`+1 < `op_len(code)` → `phase`++, `pc`←`pc`+1, go to S_ARG.
    - otherwise → `pc`←`pc`+1, go to S_OP.
- The unit issues at least one step per instruction. A zero-length opcode gets one step with `phase`=0 and `data`=opcode byte.
- Operand steps:
  - The step for operand byte k has `phase`=k and `p`=opcode address+1+k.
  - Therefore the return address for a 2-operand call is `p`+2 at phase 0.
- `en`:
  - `en`=0 holds S_OP/S_ARG with `mem_req`=0.
  - A request whose ack is still outstanding stays asserted until the ack arrives.
  - `en` does not affect S_STEP.
- Address arithmetic is modulo 2^ASZ: `pc`+1 at 2^ASZ−1 wraps to 0.
- `br_psel` is ignored outside S_STEP.
- Reset, mid-request or in any state:
  - `pc`=0, state S_OP, `mem_req`=0 while `rst` is high.
  - An ack for a request issued before reset is ignored.
  - First request is at `mem_addr`=0 in the first cycle after release with `en`=1.
- Reset values of outputs: `mem_req`=0, `mem_addr`=0, `code`=nop (0x00), `phase`=0, `data`=0, `p`=0, `step`=0.

## Timing
- `mem_req`/`mem_addr` are registered outputs.
- A request stays asserted, with `mem_addr` stable, until the cycle in which `mem_ack`=1. `mem_req` deasserts in the cycle after the ack.
- Zero-wait memory (ack in the first request cycle):
  - Zero-length opcode: 2 cycles per instruction.
  - Opcode with N operand bytes: 2N+1 cycles.
- `step` is asserted in the cycle after the ack for the byte it carries. `code`/`phase`/`data`/`p` are stable and registered for that whole cycle.
- Redirect cost: `br_psel` sampled at S_STEP; the first request to `br_p_o` is issued in the next cycle.

## Structure
- Shared package `ej32_pkg` holds:
  - `opcode_t`.
  - Function `op_len(opcode_t)` returning 0/1/2:
    - 1: bipush, iload, istore.
    - 2: sipush, all if*/if_icmp*, goto, jsr, invokevirtual, donext.
    - 0: all other opcodes.
  - The `ASZ`/`DSZ` defaults.
  - FSM state enum `fetch_st_t`.
- Single module, no sub-module. The length decode is the package function.

## Test plan
- Reset release with `rst` pulsed mid-request (ack arrives 2 cycles into reset) → all outputs at their reset values; that ack is ignored; first `mem_req` at address 0x00000.
- Memory bytes 00 00 10 2A at address 0 (nop, nop, bipush 0x2A), zero-wait → three steps:
  - (code 00, phase 0, p 0)
  - (00, 0, 1)
  - (10, 0, p 3, data 2A)
  - next request at address 4.
- goto A7 00 05 at address 0x10; branching unit asserts `br_psel`, `br_p_o`=0x15 at the phase-1 step → next `mem_addr`=0x15; no request to 0x13.
- Opcode with `op_len`=2 at 0x20, `br_psel`=1 at the phase-0 step → operand byte at 0x22 is never requested; fetch resumes at the target.
- ack delayed 3 cycles plus `en` dropped during wait → `mem_req`/`mem_addr` held until the ack; after the step, no new request until `en`=1.
- sipush at 0x1FFFE → operand bytes are fetched from 0x1FFFF and 0x00000; next opcode is fetched at 0x00001.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared eJ32 definitions: opcode type, operand-length decode, fetch FSM
// states and the default datapath/address widths.
package ej32_pkg;

    localparam int DSZ_DEF = 32;
    localparam int ASZ_DEF = 17;

    typedef logic [7:0] opcode_t;

    localparam opcode_t OP_NOP           = 8'h00;
    localparam opcode_t OP_BIPUSH        = 8'h10;
    localparam opcode_t OP_SIPUSH        = 8'h11;
    localparam opcode_t OP_ILOAD         = 8'h15;
    localparam opcode_t OP_ISTORE        = 8'h36;
    localparam opcode_t OP_IFEQ          = 8'h99;
    localparam opcode_t OP_IF_ACMPNE     = 8'hA6;
    localparam opcode_t OP_GOTO          = 8'hA7;
    localparam opcode_t OP_JSR           = 8'hA8;
    localparam opcode_t OP_INVOKEVIRTUAL = 8'hB6;
    localparam opcode_t OP_IFNULL        = 8'hC6;
    localparam opcode_t OP_IFNONNULL     = 8'hC7;
    localparam opcode_t OP_DONEXT        = 8'hCA;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_ARG  = 2'd1,
        S_STEP = 2'd2
    } fetch_st_t;

    // Number of operand bytes that follow an opcode byte.
    function automatic logic [1:0] op_len(input opcode_t op);
        logic [1:0] len;
        case (op) inside
            OP_BIPUSH, OP_ILOAD, OP_ISTORE: len = 2'd1;
            OP_SIPUSH, OP_GOTO, OP_JSR, OP_INVOKEVIRTUAL, OP_DONEXT,
            OP_IFNULL, OP_IFNONNULL, [OP_IFEQ:OP_IF_ACMPNE]: len = 2'd2;
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ej32_fetch.sv
// Byte-serial instruction fetch and sequencer for the eJ32 machine. Fetches
// an opcode and its operand bytes over a req/ack port, presents one step per
// byte to the execution units, and follows redirects from the branch unit.
module ej32_fetch
    import ej32_pkg::*;
#(
    parameter int DSZ = DSZ_DEF,
    parameter int ASZ = ASZ_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic           mem_req,
    output logic [ASZ-1:0] mem_addr,
    input  logic           mem_ack,
    input  logic [7:0]     mem_data,
    input  logic           br_psel,
    input  logic [ASZ-1:0] br_p_o,
    output logic [7:0]     code,
    output logic [2:0]     phase,
    output logic [7:0]     data,
    output logic [ASZ-1:0] p,
    output logic           step
);

    // The data width only matters to the execution units; it must cover a byte.
    if (DSZ < 8) begin : g_dsz_too_small
    end

    fetch_st_t      state_r;
    logic [ASZ-1:0] pc_r;
    logic           mem_req_r;
    logic [ASZ-1:0] mem_addr_r;
    opcode_t        code_r;
    logic [2:0]     phase_r;
    logic [7:0]     data_r;
    logic [ASZ-1:0] p_r;
    logic           step_r;

    logic [ASZ-1:0] pc_inc_s;
    logic [2:0]     phase_inc_s;
    logic [1:0]     cur_len_s;
    logic [1:0]     new_len_s;
    logic           more_args_s;
    logic           ack_s;

    // Sequential address, operand-count decode and accepted-ack qualifier.
    always_comb begin
        pc_inc_s    = pc_r + {{(ASZ-1){1'b0}}, 1'b1};
        phase_inc_s = phase_r + 3'd1;
        cur_len_s   = op_len(code_r);
        new_len_s   = op_len(mem_data);
        ack_s       = mem_req_r & mem_ack;
        if (phase_inc_s < {1'b0, cur_len_s}) begin
            more_args_s = 1'b1;
        end else begin
            more_args_s = 1'b0;
        end
    end

    // Fetch sequencer: request byte, latch it, strobe one step, pick next address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_OP;
            pc_r       <= '0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
            code_r     <= OP_NOP;
            phase_r    <= 3'd0;
            data_r     <= 8'h00;
            p_r        <= '0;
            step_r     <= 1'b0;
        end else begin
            case (state_r)
                S_OP: begin
                    step_r <= 1'b0;
                    if (ack_s) begin
                        code_r  <= mem_data;
                        data_r  <= mem_data;
                        p_r     <= pc_r;
                        phase_r <= 3'd0;
                        if (new_len_s == 2'd0) begin
                            // Zero-length opcode: the opcode byte itself is the step.
                            mem_req_r <= 1'b0;
                            step_r    <= 1'b1;
                            state_r   <= S_STEP;
                        end else begin
                            // Operands follow: go straight on to the first one.
                            pc_r       <= pc_inc_s;
                            mem_addr_r <= pc_inc_s;
                            mem_req_r  <= en;
                            state_r    <= S_ARG;
                        end
                    end else if (!mem_req_r) begin
                        mem_req_r  <= en;
                        mem_addr_r <= pc_r;
                    end else begin
                        // Outstanding request holds until acknowledged.
                        mem_req_r <= mem_req_r;
                    end
                end
                S_ARG: begin
                    step_r <= 1'b0;
                    if (ack_s) begin
                        data_r    <= mem_data;
                        p_r       <= pc_r;
                        mem_req_r <= 1'b0;
                        step_r    <= 1'b1;
                        state_r   <= S_STEP;
                    end else if (!mem_req_r) begin
                        mem_req_r  <= en;
                        mem_addr_r <= pc_r;
                    end else begin
                        mem_req_r <= mem_req_r;
                    end
                end
                S_STEP: begin
                    step_r <= 1'b0;
                    if (br_psel) begin
                        // Redirect wins; unfetched operand bytes are dropped.
                        pc_r       <= br_p_o;
                        mem_addr_r <= br_p_o;
                        phase_r    <= 3'd0;
                        mem_req_r  <= en;
                        state_r    <= S_OP;
                    end else if (more_args_s) begin
                        phase_r    <= phase_inc_s;
                        pc_r       <= pc_inc_s;
                        mem_addr_r <= pc_inc_s;
                        mem_req_r  <= en;
                        state_r    <= S_ARG;
                    end else begin
                        pc_r       <= pc_inc_s;
                        mem_addr_r <= pc_inc_s;
                        mem_req_r  <= en;
                        state_r    <= S_OP;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    step_r    <= 1'b0;
                    state_r   <= S_OP;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign code     = code_r;
    assign phase    = phase_r;
    assign data     = data_r;
    assign p        = p_r;
    assign step     = step_r;

endmodule
